ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage fed by id_ex_reg: operand forwarding, ALU, branch/jump resolution, PC redirect.
//  Contains the EX/MEM pipeline register that feeds the memory stage.
//  One result per cycle; the EX/MEM register can be held by a memory-stage stall.
// PARAMETERS
//  XLEN        32   datapath width
//  RESET_PC4   0    reset value of pc_plus4_mem
// PORTS
//  clk            in   1     clock, rising edge
//  rst            in   1     synchronous, active-high reset
//  pc_ex,rd1_ex,rd2_ex,imm_ex  in XLEN  from id_ex_reg
//  rs1_ex,rs2_ex,rd_ex         in 5     register indices
//  Branch_ex,jump_ex,Alu_src_ex in 1    control
//  ALU_Control_ex in 4; branch_cond_ex in 3; Mem_Write_ex,Reg_write_ex in 1
//  Result_src_ex in 2; Store_type_ex in 2; Load_type_ex in 3
//  rd_wb          in   5     WB destination
//  Reg_write_wb   in   1     WB writes rd_wb
//  result_wb      in   XLEN  WB write-back value
//  stall_mem      in   1     hold EX/MEM register, suppress redirect
//  redirect_ex    out  1     combinational: taken branch/jump advancing this cycle
//  target_ex      out  XLEN  combinational redirect target
//  alu_result_mem,write_data_mem,pc_plus4_mem  out XLEN  registered
//  rd_mem out 5; Reg_write_mem,Mem_Write_mem out 1; Result_src_mem out 2
//  Store_type_mem out 2; Load_type_mem out 3   (all registered)
// BEHAVIOUR
//  Reset (sync): all *_mem outputs 0, except pc_plus4_mem = RESET_PC4.
//  Forwarding per operand (rs1, rs2 independently), priority:
//   1) Reg_write_mem && rd_mem!=0 && rd_mem==rsN -> fwd_mem
//   2) Reg_write_wb  && rd_wb!=0  && rd_wb==rsN  -> result_wb
//   3) else rd1_ex/rd2_ex.  x0 is never forwarded.
//   fwd_mem = pc_plus4_mem when Result_src_mem==2'b10, else alu_result_mem.
//   A load in MEM is not forwarded; the hazard unit inserts the bubble.
//  ALU: A = fwd rs1; B = Alu_src_ex ? imm_ex : fwd rs2.
//  ALU_Control codes:
//   0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA
//   8 SLT (signed), 9 SLTU, A PASSB (LUI), B AUIPC (pc_ex+imm_ex)
//   C-F produce 0.  Shift amount = B[4:0].  Arithmetic wraps mod 2^XLEN.
//  Branch compare on fwd rs1 vs fwd rs2, branch_cond_ex:
//   000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010/011 never taken.
//  taken = (Branch_ex && cond) || jump_ex.
//  target_ex = jump_ex&&Alu_src_ex (JALR) ? (A+imm_ex)&~1 : pc_ex+imm_ex.
//  redirect_ex = taken && !stall_mem; it is 0 during rst.
//  EX/MEM register on rising edge:
//   - rst: reset values.
//   - else if stall_mem: hold all values.
//   - else: load ALU result, fwd rs2 -> write_data_mem, pc_ex+4 -> pc_plus4_mem, control, rd.
//  Bubbles arrive as Reg_write_ex=Mem_Write_ex=0 and propagate unchanged.
//  stall_mem and rst together: reset wins.
//  A branch held by stall_mem redirects only in the cycle it advances.
// STRUCTURE
//  riscv_pkg: ALU_Control localparams, branch_cond codes, Result_src codes
//   (00 ALU, 01 MEM, 10 PC+4), Store_type/Load_type codes.
//  Sub-module ex_alu: combinational ALU (A, B, pc, op -> result).
//  Forwarding, branch compare and the EX/MEM register stay in ex_stage.
// TESTING
//  1 Dependent ADD after ADD, rd=rs1=5, both MEM and WB match:
//    MEM value 7, WB value 9 -> operand uses 7.
//  2 rd_mem=0, Reg_write_mem=1, rs1=0, rd1_ex=0 -> operand stays 0, no forward.
//  3 BEQ with fwd operands 3==3, pc_ex=0x100, imm=0x20:
//    redirect_ex=1, target_ex=0x120; with 3 vs 4 -> redirect_ex=0.
//  4 JALR rs1=0x1001, imm=4: target_ex=0x1004.
//    Next cycle pc_plus4_mem=pc_ex+4, Result_src_mem=10, and the dependent op gets pc+4.
//  5 stall_mem=1 for 3 cycles with a taken BNE in EX:
//    *_mem held, redirect_ex=0, then a single redirect pulse on release.
//  6 Assert rst mid-stream:
//    next edge all *_mem = reset values, Reg_write_mem=0, redirect_ex=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// ============================================================================
// Package : riscv_pkg
// Brief   : Shared encodings for the execute stage (ALU ops, branch
//           conditions, result select, load/store widths).
// Rev     : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

  // ALU_Control encodings; C..F are unused and produce zero
  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_SUB   = 4'h1;
  localparam logic [3:0] ALU_AND   = 4'h2;
  localparam logic [3:0] ALU_OR    = 4'h3;
  localparam logic [3:0] ALU_XOR   = 4'h4;
  localparam logic [3:0] ALU_SLL   = 4'h5;
  localparam logic [3:0] ALU_SRL   = 4'h6;
  localparam logic [3:0] ALU_SRA   = 4'h7;
  localparam logic [3:0] ALU_SLT   = 4'h8;
  localparam logic [3:0] ALU_SLTU  = 4'h9;
  localparam logic [3:0] ALU_PASSB = 4'hA;
  localparam logic [3:0] ALU_AUIPC = 4'hB;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] ST_B = 2'b00;
  localparam logic [1:0] ST_H = 2'b01;
  localparam logic [1:0] ST_W = 2'b10;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b011;
  localparam logic [2:0] LD_HU = 3'b100;

  // Control fields carried through the EX/MEM register
  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic [1:0] store_type;
    logic [2:0] load_type;
  } ex_mem_ctrl_t;

endpackage : riscv_pkg

`default_nettype wire

// File: rtl/ex_alu.sv
// ============================================================================
// Module : ex_alu
// Brief  : Combinational execute-stage ALU (A, B, pc, imm, op -> result).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ex_alu
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [3:0]      op_i,
  output logic [XLEN-1:0] result_o
);

  logic [4:0] shamt;
  logic       slt_bit;
  logic       sltu_bit;

  assign shamt    = b_i[4:0];
  assign slt_bit  = $signed(a_i) < $signed(b_i);
  assign sltu_bit = a_i < b_i;

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:   result_o = a_i + b_i;
      ALU_SUB:   result_o = a_i - b_i;
      ALU_AND:   result_o = a_i & b_i;
      ALU_OR:    result_o = a_i | b_i;
      ALU_XOR:   result_o = a_i ^ b_i;
      ALU_SLL:   result_o = a_i << shamt;
      ALU_SRL:   result_o = a_i >> shamt;
      ALU_SRA:   result_o = $unsigned($signed(a_i) >>> shamt);
      ALU_SLT:   result_o = {{(XLEN-1){1'b0}}, slt_bit};
      ALU_SLTU:  result_o = {{(XLEN-1){1'b0}}, sltu_bit};
      ALU_PASSB: result_o = b_i;
      // AUIPC always adds the raw immediate, independent of the B-operand mux
      ALU_AUIPC: result_o = pc_i + imm_i;
      default:   result_o = '0;
    endcase
  end

endmodule : ex_alu

`default_nettype wire

// File: rtl/ex_stage.sv
// ============================================================================
// Module : ex_stage
// Brief  : Execute stage: operand forwarding, ALU, branch/jump resolution,
//          PC redirect and the EX/MEM pipeline register.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ex_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC4 = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_ex,
  input  logic [XLEN-1:0] rd1_ex,
  input  logic [XLEN-1:0] rd2_ex,
  input  logic [XLEN-1:0] imm_ex,
  input  logic [4:0]      rs1_ex,
  input  logic [4:0]      rs2_ex,
  input  logic [4:0]      rd_ex,
  input  logic            Branch_ex,
  input  logic            jump_ex,
  input  logic            Alu_src_ex,
  input  logic [3:0]      ALU_Control_ex,
  input  logic [2:0]      branch_cond_ex,
  input  logic            Mem_Write_ex,
  input  logic            Reg_write_ex,
  input  logic [1:0]      Result_src_ex,
  input  logic [1:0]      Store_type_ex,
  input  logic [2:0]      Load_type_ex,
  input  logic [4:0]      rd_wb,
  input  logic            Reg_write_wb,
  input  logic [XLEN-1:0] result_wb,
  input  logic            stall_mem,
  output logic            redirect_ex,
  output logic [XLEN-1:0] target_ex,
  output logic [XLEN-1:0] alu_result_mem,
  output logic [XLEN-1:0] write_data_mem,
  output logic [XLEN-1:0] pc_plus4_mem,
  output logic [4:0]      rd_mem,
  output logic            Reg_write_mem,
  output logic            Mem_Write_mem,
  output logic [1:0]      Result_src_mem,
  output logic [1:0]      Store_type_mem,
  output logic [2:0]      Load_type_mem
);

  logic [XLEN-1:0] alu_result_q, alu_result_d;
  logic [XLEN-1:0] write_data_q, write_data_d;
  logic [XLEN-1:0] pc_plus4_q,   pc_plus4_d;
  ex_mem_ctrl_t    ctrl_q,       ctrl_d;

  logic [XLEN-1:0] fwd_mem;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] jalr_sum;
  logic            mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
  logic            cond_met;
  logic            taken;

  // A JAL/JALR in MEM forwards its link address rather than its ALU output
  assign fwd_mem = (ctrl_q.result_src == RES_PC4) ? pc_plus4_q : alu_result_q;

  assign mem_hit_a = ctrl_q.reg_write && (ctrl_q.rd != 5'd0) && (ctrl_q.rd == rs1_ex);
  assign mem_hit_b = ctrl_q.reg_write && (ctrl_q.rd != 5'd0) && (ctrl_q.rd == rs2_ex);
  assign wb_hit_a  = Reg_write_wb && (rd_wb != 5'd0) && (rd_wb == rs1_ex);
  assign wb_hit_b  = Reg_write_wb && (rd_wb != 5'd0) && (rd_wb == rs2_ex);

  always_comb begin
    src_a = rd1_ex;
    if (mem_hit_a)     src_a = fwd_mem;
    else if (wb_hit_a) src_a = result_wb;

    src_b = rd2_ex;
    if (mem_hit_b)     src_b = fwd_mem;
    else if (wb_hit_b) src_b = result_wb;
  end

  assign alu_b = Alu_src_ex ? imm_ex : src_b;

  ex_alu #(
    .XLEN (XLEN)
  ) u_alu (
    .a_i      (src_a),
    .b_i      (alu_b),
    .pc_i     (pc_ex),
    .imm_i    (imm_ex),
    .op_i     (ALU_Control_ex),
    .result_o (alu_result)
  );

  always_comb begin
    cond_met = 1'b0;
    case (branch_cond_ex)
      BR_EQ:   cond_met = (src_a == src_b);
      BR_NE:   cond_met = (src_a != src_b);
      BR_LT:   cond_met = ($signed(src_a) <  $signed(src_b));
      BR_GE:   cond_met = ($signed(src_a) >= $signed(src_b));
      BR_LTU:  cond_met = (src_a <  src_b);
      BR_GEU:  cond_met = (src_a >= src_b);
      default: cond_met = 1'b0;
    endcase
  end

  assign taken       = (Branch_ex && cond_met) || jump_ex;
  assign redirect_ex = taken && !stall_mem && !rst;
  assign jalr_sum    = src_a + imm_ex;
  assign target_ex   = (jump_ex && Alu_src_ex) ? {jalr_sum[XLEN-1:1], 1'b0}
                                               : pc_ex + imm_ex;

  always_comb begin
    alu_result_d = alu_result_q;
    write_data_d = write_data_q;
    pc_plus4_d   = pc_plus4_q;
    ctrl_d       = ctrl_q;
    if (!stall_mem) begin
      alu_result_d      = alu_result;
      write_data_d      = src_b;
      pc_plus4_d        = pc_ex + XLEN'(4);
      ctrl_d.rd         = rd_ex;
      ctrl_d.reg_write  = Reg_write_ex;
      ctrl_d.mem_write  = Mem_Write_ex;
      ctrl_d.result_src = Result_src_ex;
      ctrl_d.store_type = Store_type_ex;
      ctrl_d.load_type  = Load_type_ex;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= RESET_PC4;
      ctrl_q       <= '0;
    end else begin
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      pc_plus4_q   <= pc_plus4_d;
      ctrl_q       <= ctrl_d;
    end
  end

  assign alu_result_mem = alu_result_q;
  assign write_data_mem = write_data_q;
  assign pc_plus4_mem   = pc_plus4_q;
  assign rd_mem         = ctrl_q.rd;
  assign Reg_write_mem  = ctrl_q.reg_write;
  assign Mem_Write_mem  = ctrl_q.mem_write;
  assign Result_src_mem = ctrl_q.result_src;
  assign Store_type_mem = ctrl_q.store_type;
  assign Load_type_mem  = ctrl_q.load_type;

endmodule : ex_stage

`default_nettype wire

// File: tb/tb_ex_stage.sv
// ============================================================================
// Module : tb_ex_stage
// Brief  : Self-checking bench for ex_stage: ALU vector table, directed
//          forwarding/branch/stall/reset sequences, random vs. reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ex_stage;

  localparam logic [31:0] RST_PC4 = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_ex, rd1_ex, rd2_ex, imm_ex, result_wb;
  logic [4:0]  rs1_ex, rs2_ex, rd_ex, rd_wb;
  logic        Branch_ex, jump_ex, Alu_src_ex, Mem_Write_ex, Reg_write_ex;
  logic        Reg_write_wb, stall_mem;
  logic [3:0]  ALU_Control_ex;
  logic [2:0]  branch_cond_ex, Load_type_ex;
  logic [1:0]  Result_src_ex, Store_type_ex;
  logic        redirect_ex;
  logic [31:0] target_ex, alu_result_mem, write_data_mem, pc_plus4_mem;
  logic [4:0]  rd_mem;
  logic        Reg_write_mem, Mem_Write_mem;
  logic [1:0]  Result_src_mem, Store_type_mem;
  logic [2:0]  Load_type_mem;

  always #5 clk = ~clk;

  ex_stage #(
    .XLEN      (32),
    .RESET_PC4 (RST_PC4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_ex          (pc_ex),
    .rd1_ex         (rd1_ex),
    .rd2_ex         (rd2_ex),
    .imm_ex         (imm_ex),
    .rs1_ex         (rs1_ex),
    .rs2_ex         (rs2_ex),
    .rd_ex          (rd_ex),
    .Branch_ex      (Branch_ex),
    .jump_ex        (jump_ex),
    .Alu_src_ex     (Alu_src_ex),
    .ALU_Control_ex (ALU_Control_ex),
    .branch_cond_ex (branch_cond_ex),
    .Mem_Write_ex   (Mem_Write_ex),
    .Reg_write_ex   (Reg_write_ex),
    .Result_src_ex  (Result_src_ex),
    .Store_type_ex  (Store_type_ex),
    .Load_type_ex   (Load_type_ex),
    .rd_wb          (rd_wb),
    .Reg_write_wb   (Reg_write_wb),
    .result_wb      (result_wb),
    .stall_mem      (stall_mem),
    .redirect_ex    (redirect_ex),
    .target_ex      (target_ex),
    .alu_result_mem (alu_result_mem),
    .write_data_mem (write_data_mem),
    .pc_plus4_mem   (pc_plus4_mem),
    .rd_mem         (rd_mem),
    .Reg_write_mem  (Reg_write_mem),
    .Mem_Write_mem  (Mem_Write_mem),
    .Result_src_mem (Result_src_mem),
    .Store_type_mem (Store_type_mem),
    .Load_type_mem  (Load_type_mem)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model of the memory-stage latch
  logic [31:0] m_alu, m_wd, m_pc4;
  logic [4:0]  m_rd;
  logic        m_rw, m_mw;
  logic [1:0]  m_rs, m_st;
  logic [2:0]  m_lt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] regval);
    if (m_rw && m_rd != 0 && m_rd == rs) return (m_rs == 2'b10) ? m_pc4 : m_alu;
    if (Reg_write_wb && rd_wb != 0 && rd_wb == rs) return result_wb;
    return regval;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh = b % 32;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return a[31] ? ~((~a) >> sh) : (a >> sh);
      4'd8:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return b;
      4'd11: return pc_ex + imm_ex;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_cond(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return int'(a) <  int'(b);
      3'b101: return int'(a) >= int'(b);
      3'b110: return a <  b;
      3'b111: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // One cycle: check combinational outputs mid-cycle, clock, check EX/MEM
  task automatic step(output logic red, output logic [31:0] tgt);
    logic [31:0] fa, fb, e_tgt, n_alu;
    logic        e_red;
    @(negedge clk);
    fa    = ref_fwd(rs1_ex, rd1_ex);
    fb    = ref_fwd(rs2_ex, rd2_ex);
    e_red = ((Branch_ex && ref_cond(branch_cond_ex, fa, fb)) || jump_ex) && !stall_mem && !rst;
    e_tgt = (jump_ex && Alu_src_ex) ? ((fa + imm_ex) & ~32'd1) : (pc_ex + imm_ex);
    n_alu = ref_alu(ALU_Control_ex, fa, Alu_src_ex ? imm_ex : fb);
    red = redirect_ex;
    tgt = target_ex;
    chk("redirect_ex", 32'(redirect_ex), 32'(e_red));
    chk("target_ex", target_ex, e_tgt);
    @(posedge clk);
    if (rst) begin
      m_alu = 0; m_wd = 0; m_pc4 = RST_PC4; m_rd = 0; m_rw = 0; m_mw = 0;
      m_rs = 0; m_st = 0; m_lt = 0;
    end else if (!stall_mem) begin
      m_alu = n_alu; m_wd = fb; m_pc4 = pc_ex + 4; m_rd = rd_ex; m_rw = Reg_write_ex;
      m_mw = Mem_Write_ex; m_rs = Result_src_ex; m_st = Store_type_ex; m_lt = Load_type_ex;
    end
    #1;
    chk("alu_result_mem", alu_result_mem, m_alu);
    chk("write_data_mem", write_data_mem, m_wd);
    chk("pc_plus4_mem", pc_plus4_mem, m_pc4);
    chk("rd_mem", 32'(rd_mem), 32'(m_rd));
    chk("ctrl_mem", {23'd0, Reg_write_mem, Mem_Write_mem, Result_src_mem, Store_type_mem, Load_type_mem},
        {23'd0, m_rw, m_mw, m_rs, m_st, m_lt});
  endtask

  task automatic clear_inputs();
    pc_ex = 0; rd1_ex = 0; rd2_ex = 0; imm_ex = 0; result_wb = 0;
    rs1_ex = 0; rs2_ex = 0; rd_ex = 0; rd_wb = 0;
    Branch_ex = 0; jump_ex = 0; Alu_src_ex = 0; Mem_Write_ex = 0; Reg_write_ex = 0;
    Reg_write_wb = 0; stall_mem = 0; ALU_Control_ex = 0; branch_cond_ex = 0;
    Load_type_ex = 0; Result_src_ex = 0; Store_type_ex = 0;
  endtask

  task automatic randomize_inputs();
    rst            = ($urandom_range(0, 39) == 0);
    stall_mem      = ($urandom_range(0, 4) == 0);
    rs1_ex         = 5'($urandom_range(0, 7));
    rs2_ex         = 5'($urandom_range(0, 7));
    rd_ex          = 5'($urandom_range(0, 7));
    rd_wb          = 5'($urandom_range(0, 7));
    rd1_ex         = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    rd2_ex         = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    imm_ex         = $urandom;
    pc_ex          = $urandom & 32'hFFFF_FFFC;
    result_wb      = $urandom;
    Branch_ex      = 1'($urandom);
    jump_ex        = ($urandom_range(0, 3) == 0);
    Alu_src_ex     = 1'($urandom);
    ALU_Control_ex = 4'($urandom);
    branch_cond_ex = 3'($urandom);
    Mem_Write_ex   = 1'($urandom);
    Reg_write_ex   = 1'($urandom);
    Reg_write_wb   = 1'($urandom);
    Result_src_ex  = 2'($urandom_range(0, 2));
    Store_type_ex  = 2'($urandom_range(0, 2));
    Load_type_ex   = 3'($urandom_range(0, 4));
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        src;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] exp;
  } vec_t;

  vec_t        vt[15];
  logic        red;
  logic [31:0] tgt;

  initial begin
    vt[0]  = '{4'h0, 32'd5,          32'd7,          1'b0, 32'd0,          32'd0,     32'd12};
    vt[1]  = '{4'h1, 32'd5,          32'd7,          1'b0, 32'd0,          32'd0,     32'hFFFF_FFFE};
    vt[2]  = '{4'h2, 32'h0000_F0F0,  32'h0000_FF00,  1'b0, 32'd0,          32'd0,     32'h0000_F000};
    vt[3]  = '{4'h3, 32'h0000_F0F0,  32'h0000_FF00,  1'b0, 32'd0,          32'd0,     32'h0000_FFF0};
    vt[4]  = '{4'h4, 32'h0000_F0F0,  32'h0000_FF00,  1'b0, 32'd0,          32'd0,     32'h0000_0FF0};
    vt[5]  = '{4'h5, 32'd1,          32'h0000_003F,  1'b0, 32'd0,          32'd0,     32'h8000_0000};
    vt[6]  = '{4'h6, 32'h8000_0000,  32'd4,          1'b0, 32'd0,          32'd0,     32'h0800_0000};
    vt[7]  = '{4'h7, 32'h8000_0000,  32'd4,          1'b0, 32'd0,          32'd0,     32'hF800_0000};
    vt[8]  = '{4'h7, 32'h7000_0000,  32'd4,          1'b0, 32'd0,          32'd0,     32'h0700_0000};
    vt[9]  = '{4'h8, 32'hFFFF_FFFF,  32'd1,          1'b0, 32'd0,          32'd0,     32'd1};
    vt[10] = '{4'h9, 32'hFFFF_FFFF,  32'd1,          1'b0, 32'd0,          32'd0,     32'd0};
    vt[11] = '{4'hA, 32'h0000_0055,  32'd0,          1'b1, 32'h1234_5000,  32'd0,     32'h1234_5000};
    vt[12] = '{4'hB, 32'h0000_0055,  32'd0,          1'b1, 32'h0000_0020,  32'h100,   32'h0000_0120};
    vt[13] = '{4'hC, 32'd5,          32'd7,          1'b0, 32'd0,          32'd0,     32'd0};
    vt[14] = '{4'h0, 32'hFFFF_FFFF,  32'd2,          1'b0, 32'd0,          32'd0,     32'd1};

    m_alu = 0; m_wd = 0; m_pc4 = RST_PC4; m_rd = 0; m_rw = 0; m_mw = 0;
    m_rs = 0; m_st = 0; m_lt = 0;
    clear_inputs();
    rst = 1'b1;
    step(red, tgt);
    step(red, tgt);
    chk("reset_pc4", pc_plus4_mem, RST_PC4);
    chk("reset_regwrite", 32'(Reg_write_mem), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      clear_inputs();
      ALU_Control_ex = vt[i].op;
      rd1_ex = vt[i].a; rd2_ex = vt[i].b;
      Alu_src_ex = vt[i].src; imm_ex = vt[i].imm; pc_ex = vt[i].pc;
      step(red, tgt);
      chk($sformatf("vec_alu[%0d]", i), alu_result_mem, vt[i].exp);
    end

    // MEM forward beats WB forward
    clear_inputs(); rd1_ex = 3; rd2_ex = 4; rd_ex = 5; Reg_write_ex = 1;
    step(red, tgt);
    clear_inputs(); rs1_ex = 5; rd1_ex = 32'hDEAD; rd_wb = 5; Reg_write_wb = 1; result_wb = 9;
    step(red, tgt);
    chk("fwd_mem_priority", alu_result_mem, 32'd7);

    // x0 never forwarded
    clear_inputs(); rd1_ex = 32'h55; rd_ex = 0; Reg_write_ex = 1;
    step(red, tgt);
    clear_inputs();
    step(red, tgt);
    chk("x0_no_forward", alu_result_mem, 32'd0);

    // BEQ taken / not taken
    clear_inputs(); rd1_ex = 3; rd2_ex = 3; Branch_ex = 1; branch_cond_ex = 3'b000;
    pc_ex = 32'h100; imm_ex = 32'h20;
    step(red, tgt);
    chk("beq_taken", 32'(red), 32'd1);
    chk("beq_target", tgt, 32'h120);
    rd2_ex = 4;
    step(red, tgt);
    chk("beq_not_taken", 32'(red), 32'd0);

    // JALR target alignment, link forwarding
    clear_inputs(); pc_ex = 32'h200; rd1_ex = 32'h1001; imm_ex = 4; jump_ex = 1; Alu_src_ex = 1;
    rd_ex = 1; Reg_write_ex = 1; Result_src_ex = 2'b10;
    step(red, tgt);
    chk("jalr_redirect", 32'(red), 32'd1);
    chk("jalr_target", tgt, 32'h1004);
    chk("jalr_pc4", pc_plus4_mem, 32'h204);
    chk("jalr_ressrc", 32'(Result_src_mem), 32'd2);
    clear_inputs(); rs1_ex = 1;
    step(red, tgt);
    chk("link_forward", alu_result_mem, 32'h204);

    // Stall holds EX/MEM and suppresses redirect; single pulse on release
    clear_inputs(); rd1_ex = 32'h11; rd2_ex = 32'h22; rd_ex = 3; Reg_write_ex = 1;
    step(red, tgt);
    clear_inputs(); Branch_ex = 1; branch_cond_ex = 3'b001; rd1_ex = 1; rd2_ex = 2;
    pc_ex = 32'h300; imm_ex = 32'h40; rd_ex = 7; Reg_write_ex = 1; stall_mem = 1;
    for (int i = 0; i < 3; i++) begin
      step(red, tgt);
      chk("stall_no_redirect", 32'(red), 32'd0);
      chk("stall_hold_alu", alu_result_mem, 32'h33);
      chk("stall_hold_rd", 32'(rd_mem), 32'd3);
    end
    stall_mem = 0;
    step(red, tgt);
    chk("release_redirect", 32'(red), 32'd1);
    chk("release_target", tgt, 32'h340);
    clear_inputs();
    step(red, tgt);
    chk("single_pulse", 32'(red), 32'd0);

    // Reset mid-stream with a jump in EX
    clear_inputs(); rd1_ex = 1; rd2_ex = 1; rd_ex = 4; Reg_write_ex = 1; jump_ex = 1; pc_ex = 32'h400;
    step(red, tgt);
    rst = 1;
    step(red, tgt);
    chk("rst_no_redirect", 32'(red), 32'd0);
    chk("rst_regwrite", 32'(Reg_write_mem), 32'd0);
    chk("rst_pc4", pc_plus4_mem, RST_PC4);
    chk("rst_alu", alu_result_mem, 32'd0);
    rst = 0;

    for (int i = 0; i < 600; i++) begin
      randomize_inputs();
      step(red, tgt);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_ex_stage

`default_nettype wire
